// File: rtl/enc_pkg.sv
// Shared types and constants for the one-hot request encoder.
package enc_pkg;

  localparam int N_REQ  = 4;
  localparam int CODE_W = $clog2(N_REQ);

  typedef logic [CODE_W-1:0] code_t;

  // EMPTY: no code presented; FULL: out holds a code not yet accepted.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/onehot_req_pick.sv
// Combinational pick of one request line from a candidate set, searching
// upward from a start index and wrapping modulo N_REQ.
module onehot_req_pick
  import enc_pkg::*;
(
  input  logic [N_REQ-1:0] cand,
  input  code_t            start,
  output logic             any,
  output code_t            g
);

  code_t idx;
  logic  found;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default before any branch, so no path leaves a value held (no latch).
  always_comb begin
    found = 1'b0;
    g     = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = start + code_t'(k);
      if (!found && cand[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
    any = found;
  end

endmodule

// File: rtl/onehot_req_encoder.sv
// Registered 4-line request encoder with valid/ready output handshake.
// Define ONEHOT_ENC_RR_EN for round-robin selection; default is fixed priority.
module onehot_req_encoder
  import enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] in,
  output code_t            out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_REQ-1:0] pending,
  output logic             ovf
);

  state_t           state_q, state_d;
  code_t            out_q, out_d;
  logic [N_REQ-1:0] pend_q, pend_d;
  logic             ovf_q, ovf_d;

  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] grant_mask;
  logic             any;
  logic             load;
  code_t            g;
  code_t            start;

`ifdef ONEHOT_ENC_RR_EN
  code_t ptr_q, ptr_d;

  assign start = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (load) ptr_d = g + code_t'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  assign start = '0;
`endif

  assign cand = pend_q | in;

  onehot_req_pick u_pick (
    .cand  (cand),
    .start (start),
    .any   (any),
    .g     (g)
  );

  assign grant_mask = {{(N_REQ-1){1'b0}}, 1'b1} << g;
  assign load       = any && ((state_q == EMPTY) || out_ready);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    pend_d  = cand;
    // A re-strobe on the line being granted is kept pending, not dropped.
    ovf_d   = ovf_q | (|(in & pend_q & ~(load ? grant_mask : '0)));
    if (load) begin
      state_d = FULL;
      out_d   = g;
      pend_d  = cand & ~(grant_mask & ~(in & pend_q));
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      out_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out       = out_q;
  assign out_valid = (state_q == FULL);
  assign pending   = pend_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_onehot_req_encoder.sv
// Self-checking bench for onehot_req_encoder: directed scenarios plus
// randomized traffic compared against a behavioural reference model.
module tb_onehot_req_encoder;

`ifdef ONEHOT_ENC_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_s;
  logic [1:0] out_s;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] pending;
  logic       ovf;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [1:0] m_out;
  logic       m_valid;
  logic [3:0] m_pend;
  logic       m_ovf;
  int         m_ptr;

  onehot_req_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_s),
    .out       (out_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  function automatic int model_pick(input logic [3:0] c, input int start);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (start + k) % 4;
      if (c[idx]) return idx;
    end
    return -1;
  endfunction

  // Apply inputs, clock once, advance the model, then settle before sampling.
  task automatic cycle(input logic [3:0] i_v, input logic r_v, input logic rst_v);
    logic [3:0] c;
    int         g;
    bit         ld;
    in_s      = i_v;
    out_ready = r_v;
    rst       = rst_v;
    @(posedge clk);
    if (rst_v) begin
      m_out = 2'd0; m_valid = 1'b0; m_pend = 4'd0; m_ovf = 1'b0; m_ptr = 0;
    end else begin
      c  = m_pend | i_v;
      g  = model_pick(c, RR_MODE ? m_ptr : 0);
      ld = (g >= 0) && (!m_valid || r_v);
      for (int i = 0; i < 4; i++)
        if (i_v[i] && m_pend[i] && !(ld && i == g)) m_ovf = 1'b1;
      if (ld) begin
        m_out   = 2'(g);
        m_valid = 1'b1;
        if (!(m_pend[g] && i_v[g])) c[g] = 1'b0;
        m_ptr   = (g + 1) % 4;
      end else if (m_valid && r_v) begin
        m_valid = 1'b0;
      end
      m_pend = c;
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(4'b1111, 1'b1, 1'b1);
    cycle(4'b1111, 1'b1, 1'b1);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_tests++;
    if (pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending got=%b exp=0000", pending); end
    n_tests++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    n_tests++;
    if (out_s !== 2'b00) begin n_fail++; $display("FAIL reset_out got=%b exp=00", out_s); end
    // Reset in the middle of a stalled handshake discards the held code.
    cycle(4'b1000, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b1);
    n_tests++;
    if ({out_s, out_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_midflight got=%b exp=000", {out_s, out_valid});
    end
  endtask

  task automatic test_single_strobe();
    cycle(4'b0000, 1'b1, 1'b1);
    cycle(4'b0100, 1'b1, 1'b0);
    n_tests++;
    if ({out_s, out_valid} !== 3'b101) begin
      n_fail++; $display("FAIL single_present got=%b exp=101", {out_s, out_valid});
    end
    cycle(4'b0000, 1'b1, 1'b0);
    n_tests++;
    if ({out_s, out_valid} !== 3'b100) begin
      n_fail++; $display("FAIL single_drain got=%b exp=100", {out_s, out_valid});
    end
  endtask

  task automatic test_multi_hot();
    logic [1:0] exp_code [3];
    logic [3:0] exp_pend [3];
    exp_code = '{2'd0, 2'd1, 2'd3};
    exp_pend = '{4'b1010, 4'b1000, 4'b0000};
    cycle(4'b0000, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle(k == 0 ? 4'b1011 : 4'b0000, 1'b1, 1'b0);
      n_tests++;
      if ({out_s, out_valid, pending} !== {exp_code[k], 1'b1, exp_pend[k]}) begin
        n_fail++;
        $display("FAIL multi_hot[%0d] got out=%0d v=%b pend=%b exp out=%0d v=1 pend=%b",
                 k, out_s, out_valid, pending, exp_code[k], exp_pend[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    cycle(4'b0000, 1'b1, 1'b1);
    cycle(4'b0001, 1'b0, 1'b0);
    cycle(4'b0010, 1'b0, 1'b0);
    n_tests++;
    if ({out_s, out_valid, pending} !== 7'b00_1_0010) begin
      n_fail++; $display("FAIL bp_hold got=%b exp=0010010", {out_s, out_valid, pending});
    end
    cycle(4'b0000, 1'b1, 1'b0);
    n_tests++;
    if ({out_s, out_valid, pending} !== 7'b01_1_0000) begin
      n_fail++; $display("FAIL bp_release got=%b exp=0110000", {out_s, out_valid, pending});
    end
    cycle(4'b0000, 1'b1, 1'b0);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_overflow();
    cycle(4'b0000, 1'b1, 1'b1);
    cycle(4'b0001, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b0);
    n_tests++;
    if ({out_s, out_valid, pending, ovf} !== 8'b00_1_0001_0) begin
      n_fail++; $display("FAIL ovf_line0 got=%b exp=00100010", {out_s, out_valid, pending, ovf});
    end
    cycle(4'b0100, 1'b0, 1'b0);
    n_tests++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early got=%b exp=0", ovf); end
    cycle(4'b0100, 1'b0, 1'b0);
    n_tests++;
    if ({pending, ovf} !== 5'b0101_1) begin
      n_fail++; $display("FAIL ovf_set got=%b exp=01011", {pending, ovf});
    end
    for (int k = 0; k < 3; k++) cycle(4'b0000, 1'b1, 1'b0);
    n_tests++;
    if ({out_valid, ovf} !== 2'b01) begin
      n_fail++; $display("FAIL ovf_sticky got=%b exp=01", {out_valid, ovf});
    end
  endtask

  task automatic test_all_lines();
    logic [1:0] exp_code;
    cycle(4'b0000, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      cycle(4'b1111, 1'b1, 1'b0);
      exp_code = RR_MODE ? 2'(k % 4) : 2'd0;
      n_tests++;
      if ({out_s, out_valid} !== {exp_code, 1'b1}) begin
        n_fail++;
        $display("FAIL all_lines[%0d] got out=%0d v=%b exp out=%0d v=1", k, out_s, out_valid, exp_code);
      end
    end
    n_tests++;
    if (ovf !== 1'b1) begin n_fail++; $display("FAIL all_lines_ovf got=%b exp=1", ovf); end
  endtask

  task automatic test_random();
    logic [3:0] i_v;
    logic       r_v, rst_v;
    cycle(4'b0000, 1'b1, 1'b1);
    for (int k = 0; k < 400; k++) begin
      i_v   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      r_v   = ($urandom_range(0, 3) != 0);
      rst_v = ($urandom_range(0, 60) == 0);
      cycle(i_v, r_v, rst_v);
      n_tests++;
      if ({out_s, out_valid, pending, ovf} !== {m_out, m_valid, m_pend, m_ovf}) begin
        n_fail++;
        $display("FAIL random[%0d] got out=%0d v=%b pend=%b ovf=%b exp out=%0d v=%b pend=%b ovf=%b",
                 k, out_s, out_valid, pending, ovf, m_out, m_valid, m_pend, m_ovf);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_s = 4'b0000; out_ready = 1'b0;
    test_reset();
    test_single_strobe();
    test_multi_hot();
    test_backpressure();
    test_overflow();
    test_all_lines();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
